// File: rtl/crc_serial_ctrl.sv
// crc_serial_ctrl: frames a parallel request into MSB-first serial bits plus a CRC trailer
// for the serial crc engine, then returns the engine's CRC/error on a valid/ready response.
module crc_serial_ctrl #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [CRC_W-1:0]  req_crc,
    input  logic              req_chk,
    input  logic [CRC_W-1:0]  req_poly,
    input  logic              abort,
    output logic              eng_ctrl_en,
    output logic              eng_data_in,
    output logic              eng_chk_en,
    output logic [CRC_W-1:0]  eng_poly_en,
    input  logic [CRC_W-1:0]  eng_crc_seq,
    input  logic              eng_crc_error,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CRC_W-1:0]  rsp_crc,
    output logic              rsp_error,
    output logic              busy
);
    localparam int TOT = DATA_W + CRC_W;

    typedef enum logic [2:0] {IDLE, SHIFT, SETTLE, CAPTURE, DONE} state_t;

    state_t           state, state_nx;
    logic [TOT-1:0]   shreg, frame;
    logic [CNT_W-1:0] cnt;
    logic             chk, accept, last, kill;

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;

    always_comb begin
        frame    = {req_data, req_chk ? req_crc : {CRC_W{1'b0}}};
        accept   = req_valid && state == IDLE;
        last     = cnt == CNT_W'(TOT - 1);
        kill     = abort && (state == SHIFT || state == SETTLE);
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? SHIFT : IDLE;
            SHIFT:   state_nx = kill ? IDLE : last ? SETTLE : SHIFT;
            SETTLE:  state_nx = kill ? IDLE : CAPTURE;
            CAPTURE: state_nx = DONE;
            DONE:    state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // The first frame bit goes out on the accept edge, so shreg keeps only the remaining bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            cnt         <= '0;
            chk         <= 1'b0;
            eng_ctrl_en <= 1'b0;
            eng_data_in <= 1'b0;
            eng_chk_en  <= 1'b0;
            eng_poly_en <= '0;
            rsp_valid   <= 1'b0;
            rsp_crc     <= '0;
            rsp_error   <= 1'b0;
        end else if (kill) begin
            eng_ctrl_en <= 1'b0;
            eng_data_in <= 1'b0;
            eng_chk_en  <= 1'b0;
            eng_poly_en <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    shreg       <= frame << 1;
                    cnt         <= '0;
                    chk         <= req_chk;
                    eng_chk_en  <= req_chk;
                    eng_poly_en <= req_poly;
                    eng_ctrl_en <= 1'b1;
                    eng_data_in <= frame[TOT-1];
                end
                SHIFT: begin
                    shreg       <= shreg << 1;
                    cnt         <= cnt + CNT_W'(1);
                    eng_ctrl_en <= !last;
                    eng_data_in <= last ? 1'b0 : shreg[TOT-1];
                end
                CAPTURE: begin
                    rsp_crc   <= eng_crc_seq;
                    rsp_error <= chk & eng_crc_error;
                    rsp_valid <= 1'b1;
                end
                DONE: if (rsp_ready) begin
                    rsp_valid   <= 1'b0;
                    eng_chk_en  <= 1'b0;
                    eng_poly_en <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_serial_ctrl.sv
// tb_crc_serial_ctrl: drives crc_serial_ctrl against a behavioural serial CRC engine and
// scores responses against a long-division CRC reference held in a queue.
module tb_crc_serial_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready, req_chk = 1'b0, abort = 1'b0;
    logic [7:0] req_data = '0;
    logic [3:0] req_crc = '0, req_poly = '0;
    logic       eng_ctrl_en, eng_data_in, eng_chk_en, eng_crc_error;
    logic [3:0] eng_poly_en, eng_crc_seq, eng_r;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_error, busy;
    logic [3:0] rsp_crc;

    always #5 clk = ~clk;

    crc_serial_ctrl #(.DATA_W(8), .CRC_W(4), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_crc(req_crc), .req_chk(req_chk), .req_poly(req_poly),
        .abort(abort), .eng_ctrl_en(eng_ctrl_en), .eng_data_in(eng_data_in),
        .eng_chk_en(eng_chk_en), .eng_poly_en(eng_poly_en), .eng_crc_seq(eng_crc_seq),
        .eng_crc_error(eng_crc_error), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_crc(rsp_crc), .rsp_error(rsp_error), .busy(busy)
    );

    // Engine: clears whenever ctrl_en is low; its outputs are registered one cycle behind.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            eng_r         <= '0;
            eng_crc_seq   <= '0;
            eng_crc_error <= 1'b0;
        end else begin
            eng_r         <= eng_ctrl_en ? ({eng_r[2:0], eng_data_in} ^ ({4{eng_r[3]}} & eng_poly_en)) : 4'b0;
            eng_crc_seq   <= eng_r;
            eng_crc_error <= eng_chk_en && eng_r != 4'b0;
        end

    typedef struct {logic [3:0] crc; logic err;} exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    logic [11:0] r_bits;
    int r_ctrl, r_lat, r_gap;
    logic [3:0] r_crc;
    logic r_err, r_stable, r_hold_ok, r_ready_low, r_idle_ok;

    function automatic logic [3:0] crc_ref(input logic [11:0] v, input logic [3:0] p);
        logic [11:0] t;
        t = v;
        for (int i = 11; i >= 4; i--)
            if (t[i]) t[i-:5] = t[i-:5] ^ {1'b1, p};
        return t[3:0];
    endfunction

    task automatic run_frame(input logic [7:0] d, input logic [3:0] c, input logic chk,
                             input logic [3:0] p, input int hold, input logic ab);
        exp_t e;
        e.crc = crc_ref({d, chk ? c : 4'b0}, p);
        e.err = chk && e.crc != 4'b0;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_data = d; req_crc = c; req_chk = chk; req_poly = p; abort = ab;
        @(posedge clk);
        #1 req_valid = 1'b0; abort = 1'b0;
        req_data = ~d; req_crc = ~c; req_chk = ~chk; req_poly = ~p;
        r_lat = -1; r_ctrl = 0; r_gap = 0; r_bits = '0; r_hold_ok = 1'b1; r_ready_low = 1'b1;
        for (int i = 0; i < 40 && r_lat < 0; i++) begin
            @(negedge clk);
            if (i < 12) r_bits[11-i] = eng_data_in;
            else if (!eng_ctrl_en && !eng_data_in) r_gap++;
            r_ctrl += int'(eng_ctrl_en);
            if (eng_chk_en !== chk || eng_poly_en !== p) r_hold_ok = 1'b0;
            if (req_ready) r_ready_low = 1'b0;
            if (rsp_valid) r_lat = i;
        end
        r_crc = rsp_crc; r_err = rsp_error; r_stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || rsp_crc !== r_crc || rsp_error !== r_err) r_stable = 1'b0;
            if (req_ready || eng_ctrl_en) r_ready_low = 1'b0;
            if (eng_chk_en !== chk || eng_poly_en !== p) r_hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        r_idle_ok = req_ready && !rsp_valid && !busy && !eng_chk_en && eng_poly_en == 4'b0;
    endtask

    task automatic test_reset();
        total++; if (req_ready !== 1'b1 || busy !== 1'b0 || eng_ctrl_en !== 1'b0 || rsp_valid !== 1'b0 || eng_poly_en !== 4'b0)
            begin bad++; $display("FAIL reset_state got rdy=%b busy=%b ctrl=%b vld=%b poly=%b want 1 0 0 0 0000", req_ready, busy, eng_ctrl_en, rsp_valid, eng_poly_en); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_data = 8'hA6; req_chk = 1'b1; req_crc = 4'hE; req_poly = 4'b0011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (eng_ctrl_en !== 1'b1 || busy !== 1'b1)
            begin bad++; $display("FAIL reset_preshift got ctrl=%b busy=%b want 1 1", eng_ctrl_en, busy); end
        rst_n = 1'b0;
        #1;
        total++; if (eng_ctrl_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || eng_chk_en !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL reset_async got ctrl=%b vld=%b rdy=%b chk=%b busy=%b want 0 0 1 0 0", eng_ctrl_en, rsp_valid, req_ready, eng_chk_en, busy); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_generate();
        exp_t e;
        run_frame(8'b1010_0110, 4'b0000, 1'b0, 4'b0011, 0, 1'b0);
        e = sb.pop_front();
        total++; if (r_bits !== 12'b1010_0110_0000) begin bad++; $display("FAIL gen_bits got=%b want=101001100000", r_bits); end
        total++; if (r_ctrl !== 12) begin bad++; $display("FAIL gen_ctrl_len got=%0d want=12", r_ctrl); end
        total++; if (r_lat !== 14) begin bad++; $display("FAIL gen_latency got=%0d want=14", r_lat); end
        total++; if (r_crc !== e.crc || r_err !== e.err) begin bad++; $display("FAIL gen_sb got=%b/%b want=%b/%b", r_crc, r_err, e.crc, e.err); end
        total++; if (r_crc !== 4'b1110) begin bad++; $display("FAIL gen_crc got=%b want=1110", r_crc); end
        total++; if (!r_hold_ok || !r_idle_ok) begin bad++; $display("FAIL gen_hold got hold=%b idle=%b want 1 1", r_hold_ok, r_idle_ok); end
    endtask

    task automatic test_check_good();
        exp_t e;
        run_frame(8'b1010_0110, 4'b1110, 1'b1, 4'b0011, 0, 1'b0);
        e = sb.pop_front();
        total++; if (r_bits !== 12'b1010_0110_1110) begin bad++; $display("FAIL chk_bits got=%b want=101001101110", r_bits); end
        total++; if (!r_hold_ok) begin bad++; $display("FAIL chk_en_hold got=0 want=1"); end
        total++; if (r_crc !== e.crc || r_err !== e.err) begin bad++; $display("FAIL chk_good_sb got=%b/%b want=%b/%b", r_crc, r_err, e.crc, e.err); end
        total++; if (r_err !== 1'b0 || !r_idle_ok) begin bad++; $display("FAIL chk_good_err got err=%b idle=%b want 0 1", r_err, r_idle_ok); end
    endtask

    task automatic test_check_bad();
        exp_t e;
        run_frame(8'b1010_0110, 4'b1111, 1'b1, 4'b0011, 0, 1'b0);
        e = sb.pop_front();
        total++; if (r_crc !== e.crc || r_err !== e.err) begin bad++; $display("FAIL chk_bad_sb got=%b/%b want=%b/%b", r_crc, r_err, e.crc, e.err); end
        total++; if (r_err !== 1'b1) begin bad++; $display("FAIL chk_bad_err got=%b want=1", r_err); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        run_frame(8'b1010_0110, 4'b0000, 1'b0, 4'b0011, 0, 1'b0);
        e = sb.pop_front();
        total++; if (r_crc !== e.crc) begin bad++; $display("FAIL b2b_first got=%b want=%b", r_crc, e.crc); end
        run_frame(8'b1010_0010, 4'b0000, 1'b0, 4'b0011, 5, 1'b0);
        e = sb.pop_front();
        total++; if (r_crc !== e.crc || r_err !== e.err) begin bad++; $display("FAIL b2b_sb got=%b/%b want=%b/%b", r_crc, r_err, e.crc, e.err); end
        total++; if (r_crc !== 4'b0010) begin bad++; $display("FAIL b2b_crc got=%b want=0010", r_crc); end
        total++; if (!r_stable) begin bad++; $display("FAIL b2b_stable got=0 want=1"); end
        total++; if (!r_ready_low || !r_idle_ok) begin bad++; $display("FAIL b2b_ready got low=%b idle=%b want 1 1", r_ready_low, r_idle_ok); end
        total++; if (r_gap < 3) begin bad++; $display("FAIL b2b_gap got=%0d want>=3", r_gap); end
    endtask

    task automatic test_abort();
        exp_t e;
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_data = 8'hA6; req_chk = 1'b1; req_crc = 4'hE; req_poly = 4'b0011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        total++; if (eng_ctrl_en !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || eng_chk_en !== 1'b0 || eng_poly_en !== 4'b0)
            begin bad++; $display("FAIL abort_stop got ctrl=%b busy=%b rdy=%b chk=%b poly=%b want 0 0 1 0 0000", eng_ctrl_en, busy, req_ready, eng_chk_en, eng_poly_en); end
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_rsp got=%b want=0", seen); end
        run_frame(8'b1010_0110, 4'b0000, 1'b0, 4'b0011, 0, 1'b1);
        e = sb.pop_front();
        total++; if (r_crc !== e.crc || r_crc !== 4'b1110 || r_lat !== 14) begin bad++; $display("FAIL abort_next got crc=%b lat=%0d want=%b 14", r_crc, r_lat, e.crc); end
    endtask

    initial begin
        #2;
        test_reset();
        test_generate();
        test_check_good();
        test_check_bad();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
